ps2_frame_receiver: RTL and testbench

PS2_FRAME_RECEIVER -- requirements
Module: ps2_frame_receiver

---
 rtl/ps2_frame_receiver.sv | 162 ++++++++++++++++
 tb/tb_ps2_frame_receiver.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_receiver.sv
// Purpose : receives 11-bit PS/2 device frames (start, 8 data LSB first, parity, stop)
//           and presents the data byte plus raw parity bit to a downstream checker.
// Latency : frameValid rises on the 3rd clk edge after the edge that first samples
//           ps2Clk low for the stop bit (2 sync flops + 1 registered edge detect).
// Backpressure : none; the PS/2 device cannot be stalled, so every result is a
//           one-cycle pulse and the data/parity outputs hold until the next good frame.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   ps2Clk, ps2Data   raw PS/2 lines, asynchronous to clk
//   scanCodeForCheck  last good data byte
//   parityCheckBit    parity bit received with scanCodeForCheck (not evaluated here)
//   frameValid        one-cycle pulse: new scanCodeForCheck/parityCheckBit pair
//   framingError      one-cycle pulse: bad stop bit or inter-edge timeout
module ps2_frame_receiver #(
   parameter int unsigned TIMEOUT_CYCLES = 5000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2Clk,
   input  logic       ps2Data,
   output logic [7:0] scanCodeForCheck,
   output logic       parityCheckBit,
   output logic       frameValid,
   output logic       framingError
);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   // Synchronizers and edge detect; all reset to the idle-high line level so
   // leaving reset never looks like a falling edge.
   logic clk_s1_q, clk_s1_d;
   logic clk_s2_q, clk_s2_d;       // sClk
   logic prev_clk_q, prev_clk_d;
   logic data_s1_q, data_s1_d;
   logic data_s2_q, data_s2_d;     // sData
   logic fall_edge_q, fall_edge_d;
   logic data_smp_q, data_smp_d;   // sData captured alongside fall_edge_q

   state_t      state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic        par_q, par_d;
   logic [15:0] idle_cnt_q, idle_cnt_d;
   logic [7:0]  scan_q, scan_d;
   logic        par_out_q, par_out_d;
   logic        frame_vld_q, frame_vld_d;
   logic        frame_err_q, frame_err_d;

   always_comb begin
      clk_s1_d    = ps2Clk;
      clk_s2_d    = clk_s1_q;
      prev_clk_d  = clk_s2_q;
      data_s1_d   = ps2Data;
      data_s2_d   = data_s1_q;
      fall_edge_d = prev_clk_q & ~clk_s2_q;
      data_smp_d  = data_s2_q;
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      par_d       = par_q;
      scan_d      = scan_q;
      par_out_d   = par_out_q;
      frame_vld_d = 1'b0;
      frame_err_d = 1'b0;

      // Idle counter measures time since the last accepted edge of a frame.
      if (state_q == IDLE || fall_edge_q) begin
         idle_cnt_d = 16'd0;
      end else begin
         idle_cnt_d = idle_cnt_q + 16'd1;
      end

      if (fall_edge_q) begin
         // An edge always takes priority over a coincident timeout.
         unique case (state_q)
            IDLE: begin
               if (!data_smp_q) begin
                  state_d   = DATA;
                  bit_cnt_d = 3'd0;
               end
            end
            DATA: begin
               shift_d = {data_smp_q, shift_q[7:1]};
               if (bit_cnt_q == 3'd7) begin
                  state_d = PARITY;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
            PARITY: begin
               par_d   = data_smp_q;
               state_d = STOP;
            end
            STOP: begin
               if (data_smp_q) begin
                  scan_d      = shift_q;
                  par_out_d   = par_q;
                  frame_vld_d = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE && idle_cnt_q == TIMEOUT_LAST) begin
         state_d     = IDLE;
         idle_cnt_d  = 16'd0;
         frame_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         clk_s1_q    <= 1'b1;
         clk_s2_q    <= 1'b1;
         prev_clk_q  <= 1'b1;
         data_s1_q   <= 1'b1;
         data_s2_q   <= 1'b1;
         fall_edge_q <= 1'b0;
         data_smp_q  <= 1'b1;
         state_q     <= IDLE;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'd0;
         par_q       <= 1'b0;
         idle_cnt_q  <= 16'd0;
         scan_q      <= 8'd0;
         par_out_q   <= 1'b0;
         frame_vld_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         clk_s1_q    <= clk_s1_d;
         clk_s2_q    <= clk_s2_d;
         prev_clk_q  <= prev_clk_d;
         data_s1_q   <= data_s1_d;
         data_s2_q   <= data_s2_d;
         fall_edge_q <= fall_edge_d;
         data_smp_q  <= data_smp_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         par_q       <= par_d;
         idle_cnt_q  <= idle_cnt_d;
         scan_q      <= scan_d;
         par_out_q   <= par_out_d;
         frame_vld_q <= frame_vld_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign scanCodeForCheck = scan_q;
   assign parityCheckBit   = par_out_q;
   assign frameValid       = frame_vld_q;
   assign framingError     = frame_err_q;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Bench for ps2_frame_receiver: table of whole frames with expected results, hand-written
// latency / timeout / spurious-start / mid-frame-reset sequences, then random frames
// checked against a frame-level model (stop=1 -> new byte, stop=0 -> error, values held).
module tb_ps2_frame_receiver;

   localparam int TMO  = 100;
   localparam int HALF = 10;   // clk cycles per PS/2 half period

   logic       clk = 1'b0;
   logic       reset;
   logic       ps2Clk;
   logic       ps2Data;
   logic [7:0] scanCodeForCheck;
   logic       parityCheckBit;
   logic       frameValid;
   logic       framingError;

   ps2_frame_receiver #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk              (clk),
      .reset            (reset),
      .ps2Clk           (ps2Clk),
      .ps2Data          (ps2Data),
      .scanCodeForCheck (scanCodeForCheck),
      .parityCheckBit   (parityCheckBit),
      .frameValid       (frameValid),
      .framingError     (framingError)
   );

   always #5 clk = ~clk;

   int tests  = 0;
   int failed = 0;

   // Pulse monitor
   int   fv_cnt = 0, fe_cnt = 0, overlap = 0, wide = 0;
   logic fv_prev = 1'b0, fe_prev = 1'b0;
   always @(negedge clk) begin
      if (frameValid)   fv_cnt++;
      if (framingError) fe_cnt++;
      if (frameValid && framingError) overlap++;
      if ((frameValid && fv_prev) || (framingError && fe_prev)) wide++;
      fv_prev = frameValid;
      fe_prev = framingError;
   end

   // Frame-level reference: values last delivered by a good frame
   logic [7:0] m_code;
   logic       m_par;

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       stop;
      int         exp_fv;
      int         exp_fe;
      logic [7:0] exp_code;
      logic       exp_par;
   } vec_t;
   vec_t vec[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ps2_bit(input logic b);
      @(negedge clk);
      ps2Data = b;
      wait_cycles(HALF);
      ps2Clk = 1'b0;
      wait_cycles(HALF);
      ps2Clk = 1'b1;
   endtask

   // fr = {stop, parity, data[7:0], start}; sends bits 0..n-1
   task automatic send_bits(input logic [10:0] fr, input int n);
      for (int i = 0; i < n; i++) ps2_bit(fr[i]);
   endtask

   task automatic frame_and_check(input string name, input logic [7:0] d, input logic p,
                                  input logic s, input int efv, input int efe,
                                  input logic [7:0] ecode, input logic epar);
      int fv0, fe0;
      fv0 = fv_cnt;
      fe0 = fe_cnt;
      send_bits({s, p, d, 1'b0}, 11);
      wait_cycles(5);
      check({name, " frameValid count"}, fv_cnt - fv0, efv);
      check({name, " framingError count"}, fe_cnt - fe0, efe);
      check({name, " scanCode"}, {24'd0, scanCodeForCheck}, {24'd0, ecode});
      check({name, " parity"}, {31'd0, parityCheckBit}, {31'd0, epar});
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int fv0, fe0, lat;
      logic [7:0] d;
      logic p, s;

      vec[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1'b0};
      vec[1] = '{8'hF0, 1'b1, 1'b1, 1, 0, 8'hF0, 1'b1};  // back-to-back after 0x1C
      vec[2] = '{8'hAA, 1'b0, 1'b0, 0, 1, 8'hF0, 1'b1};  // bad stop keeps old values
      vec[3] = '{8'h55, 1'b0, 1'b1, 1, 0, 8'h55, 1'b0};  // wrong parity still valid
      vec[4] = '{8'h00, 1'b1, 1'b1, 1, 0, 8'h00, 1'b1};
      vec[5] = '{8'hFF, 1'b1, 1'b0, 0, 1, 8'h00, 1'b1};
      vec[6] = '{8'h81, 1'b0, 1'b1, 1, 0, 8'h81, 1'b0};

      reset   = 1'b1;
      ps2Clk  = 1'b1;
      ps2Data = 1'b1;
      wait_cycles(3);
      check("reset scanCode", {24'd0, scanCodeForCheck}, 32'd0);
      check("reset parity", {31'd0, parityCheckBit}, 32'd0);
      check("reset frameValid", {31'd0, frameValid}, 32'd0);
      check("reset framingError", {31'd0, framingError}, 32'd0);
      reset = 1'b0;
      wait_cycles(5);
      check("post-reset no pulses", fv_cnt + fe_cnt, 0);

      for (int i = 0; i < 7; i++)
         frame_and_check($sformatf("vec%0d", i), vec[i].data, vec[i].par, vec[i].stop,
                         vec[i].exp_fv, vec[i].exp_fe, vec[i].exp_code, vec[i].exp_par);

      // Latency: stop-bit fall sampled at posedge 1 -> frameValid visible after posedge 4
      fv0 = fv_cnt;
      send_bits({1'b1, 1'b1, 8'h3C, 1'b0}, 10);
      @(negedge clk);
      ps2Data = 1'b1;
      wait_cycles(HALF);
      ps2Clk = 1'b0;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (frameValid && lat < 0) lat = k;
      end
      @(negedge clk);
      ps2Clk = 1'b1;
      wait_cycles(5);
      check("latency edges", lat, 4);
      check("latency frame count", fv_cnt - fv0, 1);
      check("latency scanCode", {24'd0, scanCodeForCheck}, 32'h3C);

      // Timeout: clock stops after 4 data bits; edge acted on at posedge 4,
      // error follows TMO edges later
      fv0 = fv_cnt;
      fe0 = fe_cnt;
      send_bits({1'b1, 1'b0, 8'h5A, 1'b0}, 4);
      @(negedge clk);
      ps2Data = 1'b1;   // bit 4 of frame = data[3] of 0x5A
      wait_cycles(HALF);
      ps2Clk = 1'b0;
      lat = -1;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk);
         #1;
         if (k == HALF) ps2Clk = 1'b1;
         if (framingError && lat < 0) lat = k;
      end
      check("timeout edges", lat, TMO + 4);
      check("timeout error count", fe_cnt - fe0, 1);
      check("timeout no frame", fv_cnt - fv0, 0);
      check("timeout keeps scanCode", {24'd0, scanCodeForCheck}, 32'h3C);
      frame_and_check("after timeout", 8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1'b0);

      // Spurious start (data high) in IDLE is ignored
      fv0 = fv_cnt;
      fe0 = fe_cnt;
      ps2_bit(1'b1);
      wait_cycles(HALF);
      check("spurious no activity", (fv_cnt - fv0) + (fe_cnt - fe0), 0);
      frame_and_check("after spurious", 8'hE7, 1'b1, 1'b1, 1, 0, 8'hE7, 1'b1);

      // Reset after the parity bit of 0x55 discards the frame silently
      fv0 = fv_cnt;
      fe0 = fe_cnt;
      send_bits({1'b1, 1'b1, 8'h55, 1'b0}, 10);
      @(negedge clk);
      reset = 1'b1;
      wait_cycles(2);
      reset = 1'b0;
      wait_cycles(HALF);
      check("midreset no pulses", (fv_cnt - fv0) + (fe_cnt - fe0), 0);
      check("midreset scanCode", {24'd0, scanCodeForCheck}, 32'd0);
      check("midreset parity", {31'd0, parityCheckBit}, 32'd0);
      frame_and_check("after midreset", 8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1'b0);

      // Random frames against the frame-level model
      m_code = 8'h1C;
      m_par  = 1'b0;
      for (int i = 0; i < 30; i++) begin
         d = 8'($urandom_range(0, 255));
         p = 1'($urandom_range(0, 1));
         s = ($urandom_range(0, 4) != 0);
         if (s) begin
            m_code = d;
            m_par  = p;
         end
         frame_and_check($sformatf("rand%0d", i), d, p, s, s ? 1 : 0, s ? 0 : 1, m_code, m_par);
      end

      check("pulses never overlap", overlap, 0);
      check("pulses one cycle wide", wide, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
